adder_8_bits: RTL and testbench

Registered 8-bit binary adder with carry-in and carry-out, used as the arithmetic core of the datapath's operator unit. Each clock it adds two unsigned 8-bit operands plus a 1-bit carry-in through a ripple-carry chain of eight full adders. It presents the 8-bit sum and carry-out from output registers one cycle later.

---
 rtl/adder_8_bits_if.sv | 25 ++
 rtl/adder_8_bits.sv | 63 ++++++
 tb/tb_adder_8_bits.sv | 122 ++++++++++++
 3 files changed

// File: rtl/adder_8_bits_if.sv
// adder_8_bits_if: operand/result bundle for the registered 8-bit adder.
//   A, B  : unsigned 8-bit operands (driven by master)
//   Cin   : carry-in, weight 1 (driven by master)
//   S     : registered sum bits [7:0] (driven by slave)
//   Cout  : registered carry-out, sum bit 8 (driven by slave)
//   OVF   : registered signed overflow (only with ADDER_FLAGS_EN)
//   ZERO  : registered zero flag (only with ADDER_FLAGS_EN)
// Optional feature macro: ADDER_FLAGS_EN.
interface adder_8_bits_if;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic [7:0] S;
    logic       Cout;
`ifdef ADDER_FLAGS_EN
    logic       OVF;
    logic       ZERO;

    modport master (output A, B, Cin, input S, Cout, OVF, ZERO);
    modport slave  (input A, B, Cin, output S, Cout, OVF, ZERO);
`else
    modport master (output A, B, Cin, input S, Cout);
    modport slave  (input A, B, Cin, output S, Cout);
`endif
endinterface

// File: rtl/adder_8_bits.sv
// adder_8_bits: registered 8-bit ripple-carry adder with carry-in/carry-out.
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   bus : adder_8_bits_if.slave (A, B, Cin in; S, Cout [, OVF, ZERO] out)
// Results appear one clock after the operands are sampled. With the macro
// ADDER_FLAGS_EN defined, registered OVF and ZERO flags are also produced.
module adder_8_bits (
    input logic           clk,
    input logic           rst,
    adder_8_bits_if.slave bus
);

    logic [8:0] carry;
    logic [7:0] sum_d;
    logic [7:0] sum_q;
    logic       cout_q;

    // Explicit ripple chain; no lookahead, carry[i+1] depends on carry[i].
    always_comb begin
        carry    = '0;
        sum_d    = '0;
        carry[0] = bus.Cin;
        for (int i = 0; i < 8; i++) begin
            sum_d[i]   = bus.A[i] ^ bus.B[i] ^ carry[i];
            carry[i+1] = (bus.A[i] & bus.B[i]) | (bus.A[i] & carry[i]) |
                         (bus.B[i] & carry[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 8'h00;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= carry[8];
        end
    end

    assign bus.S    = sum_q;
    assign bus.Cout = cout_q;

`ifdef ADDER_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    // Zero looks at the 8-bit sum only, so a wrap to 0x00 with Cout=1 is zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            ovf_q  <= carry[8] ^ carry[7];
            zero_q <= (sum_d == 8'h00);
        end
    end

    assign bus.OVF  = ovf_q;
    assign bus.ZERO = zero_q;
`endif

endmodule

// File: tb/tb_adder_8_bits.sv
// tb_adder_8_bits: scoreboard bench for adder_8_bits. Each rising edge the
// monitor predicts the registered result from the inputs in force at that
// edge, queues it, and compares it against the outputs just after the edge.
module tb_adder_8_bits;

    typedef struct packed {
        logic [7:0] s;
        logic       cout;
        logic       ovf;
        logic       zero;
    } exp_t;

    logic clk;
    logic rst;
    logic mon_en;
    int   tests_run;
    int   tests_failed;
    exp_t exp_q[$];
    exp_t exp_push;
    exp_t exp_pop;

    adder_8_bits_if bus ();

    adder_8_bits u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [8:0] obs,
                            input logic [8:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic r, input logic [7:0] a,
                                   input logic [7:0] b, input logic ci);
        exp_t e;
        logic [8:0] full;
        if (r) begin
            e.s    = 8'h00;
            e.cout = 1'b0;
            e.ovf  = 1'b0;
            e.zero = 1'b1;
        end else begin
            full   = {1'b0, a} + {1'b0, b} + {8'b0, ci};
            e.s    = full[7:0];
            e.cout = full[8];
            e.ovf  = (a[7] == b[7]) && (full[7] != a[7]);
            e.zero = (full[7:0] == 8'h00);
        end
        return e;
    endfunction

    // Monitor: predict at the edge, compare 1 time unit after it.
    always @(posedge clk) begin
        if (mon_en) begin
            exp_push = model(rst, bus.A, bus.B, bus.Cin);
            exp_q.push_back(exp_push);
            #1;
            if (exp_q.size() == 0) begin
                check_eq("queue_underflow", 9'd0, 9'd1);
            end else begin
                exp_pop = exp_q.pop_front();
                check_eq("S", {1'b0, bus.S}, {1'b0, exp_pop.s});
                check_eq("Cout", {8'b0, bus.Cout}, {8'b0, exp_pop.cout});
`ifdef ADDER_FLAGS_EN
                check_eq("OVF", {8'b0, bus.OVF}, {8'b0, exp_pop.ovf});
                check_eq("ZERO", {8'b0, bus.ZERO}, {8'b0, exp_pop.zero});
`endif
            end
        end
    end

    task automatic drive(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic ci);
        @(negedge clk);
        rst     = r;
        bus.A   = a;
        bus.B   = b;
        bus.Cin = ci;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        // Reset with all-ones operands in force: sum must not leak through.
        rst     = 1'b1;
        bus.A   = 8'hFF;
        bus.B   = 8'hFF;
        bus.Cin = 1'b1;
        mon_en  = 1'b1;

        drive(1'b0, 8'hFF, 8'hFF, 1'b1);  // max: S=FF Cout=1
        drive(1'b0, 8'h21, 8'h2D, 1'b1);  // basic: 4F
        drive(1'b0, 8'hA1, 8'h8F, 1'b0);  // carry + overflow: 30
        drive(1'b0, 8'h79, 8'h6D, 1'b1);  // overflow, no carry: E7
        drive(1'b0, 8'hE9, 8'h67, 1'b0);  // carry, no overflow: 50
        drive(1'b0, 8'h80, 8'h80, 1'b0);  // wrap to zero
        drive(1'b1, 8'h01, 8'h01, 1'b0);  // reset wins over new inputs
        drive(1'b0, 8'h00, 8'h00, 1'b0);  // zero sum from zero inputs
        drive(1'b0, 8'h7F, 8'h00, 1'b1);  // carry ripples through 7 bits

        for (int i = 0; i < 40; i++) begin
            drive(($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        mon_en = 1'b0;
        check_eq("queue_drained", 9'(exp_q.size()), 9'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
